// File: rtl/md_unit.sv
// rtl/md_unit.sv - multi-cycle multiply/divide unit owning the HI/LO registers
module md_unit #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        Start,
    input  logic [1:0]  MDOp,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic        HIWrite,
    input  logic        LOWrite,
    input  logic        MFSel,
    output logic [31:0] MDOut,
    output logic        Busy,
    output logic        Done
);

    localparam int MAX_CYCLES = (DIV_CYCLES > MULT_CYCLES) ? DIV_CYCLES : MULT_CYCLES;
    localparam int CNT_W      = $clog2(MAX_CYCLES + 1);
    localparam logic [CNT_W-1:0] MULT_CNT = CNT_W'(MULT_CYCLES);
    localparam logic [CNT_W-1:0] DIV_CNT  = CNT_W'(DIV_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } stateT;

    stateT state;
    stateT nextState;

    logic [31:0]      hi;
    logic [31:0]      lo;
    logic [31:0]      resHi;
    logic [31:0]      resLo;
    logic             resWrite;
    logic [CNT_W-1:0] cnt;
    logic             doneReg;

    logic [31:0] calcHi;
    logic [31:0] calcLo;
    logic        calcWrite;
    logic [63:0] prodS;
    logic [63:0] prodU;
    logic [31:0] divisor;
    logic [31:0] quotS;
    logic [31:0] remS;
    logic [31:0] quotU;
    logic [31:0] remU;
    logic        divOverflow;

    // Result arithmetic for the operation being issued; a zero divisor is
    // replaced by 1 so the dividers stay defined, and the write is suppressed.
    always_comb begin
        prodS       = $signed({{32{A[31]}}, A}) * $signed({{32{B[31]}}, B});
        prodU       = {32'd0, A} * {32'd0, B};
        divisor     = (B == 32'd0) ? 32'd1 : B;
        divOverflow = (A == 32'h8000_0000) && (B == 32'hFFFF_FFFF);
        quotS       = $signed(A) / $signed(divisor);
        remS        = $signed(A) % $signed(divisor);
        quotU       = A / divisor;
        remU        = A % divisor;
        calcHi      = 32'd0;
        calcLo      = 32'd0;
        calcWrite   = 1'b1;
        case (MDOp)
            2'b00: begin
                calcHi = prodS[63:32];
                calcLo = prodS[31:0];
            end
            2'b01: begin
                calcHi = prodU[63:32];
                calcLo = prodU[31:0];
            end
            2'b10: begin
                calcHi    = divOverflow ? 32'd0 : remS;
                calcLo    = divOverflow ? 32'h8000_0000 : quotS;
                calcWrite = (B != 32'd0);
            end
            default: begin
                calcHi    = remU;
                calcLo    = quotU;
                calcWrite = (B != 32'd0);
            end
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    // Next-state: leave IDLE on Start, return when the last busy cycle ends
    always_comb begin
        nextState = state;
        case (state)
            IDLE: if (Start) nextState = RUN;
            RUN:  if (cnt == CNT_ONE) nextState = IDLE;
            default: nextState = IDLE;
        endcase
    end

    // Datapath: latch result at issue, count down, commit to HI/LO on the last cycle
    always_ff @(posedge clk) begin
        if (reset) begin
            hi       <= 32'd0;
            lo       <= 32'd0;
            resHi    <= 32'd0;
            resLo    <= 32'd0;
            resWrite <= 1'b0;
            cnt      <= '0;
            doneReg  <= 1'b0;
        end else begin
            doneReg <= 1'b0;
            if (state == IDLE) begin
                if (Start) begin
                    resHi    <= calcHi;
                    resLo    <= calcLo;
                    resWrite <= calcWrite;
                    cnt      <= MDOp[1] ? DIV_CNT : MULT_CNT;
                end else begin
                    if (HIWrite) hi <= A;
                    if (LOWrite) lo <= A;
                end
            end else begin
                cnt <= cnt - CNT_ONE;
                if (cnt == CNT_ONE) begin
                    doneReg <= 1'b1;
                    if (resWrite) begin
                        hi <= resHi;
                        lo <= resLo;
                    end
                end
            end
        end
    end

    // Busy comes straight from the state flop so the stall path sees no glitches
    assign Busy  = (state == RUN);
    assign Done  = doneReg;
    assign MDOut = MFSel ? hi : lo;

endmodule

// File: tb/tb_md_unit.sv
// tb/tb_md_unit.sv - directed self-checking bench for md_unit
module tb_md_unit;

    logic        clk;
    logic        reset;
    logic        Start;
    logic [1:0]  MDOp;
    logic [31:0] A;
    logic [31:0] B;
    logic        HIWrite;
    logic        LOWrite;
    logic        MFSel;
    logic [31:0] MDOut;
    logic        Busy;
    logic        Done;

    int checks = 0;
    int errors = 0;

    md_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk(clk), .reset(reset), .Start(Start), .MDOp(MDOp), .A(A), .B(B),
        .HIWrite(HIWrite), .LOWrite(LOWrite), .MFSel(MFSel),
        .MDOut(MDOut), .Busy(Busy), .Done(Done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkVal(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // no issue or HI/LO write may be presented while an op is in flight
    always @(negedge clk) begin
        if (Busy === 1'b1) checkVal("protocol", {61'd0, Start, HIWrite, LOWrite}, 64'd0);
    end

    task automatic checkHiLo(input string tag, input logic [31:0] expHi, input logic [31:0] expLo);
        MFSel = 1'b1;
        #1 checkVal({tag, ".hi"}, {32'd0, MDOut}, {32'd0, expHi});
        MFSel = 1'b0;
        #1 checkVal({tag, ".lo"}, {32'd0, MDOut}, {32'd0, expLo});
    endtask

    // called at a negedge; returns at the negedge of the cycle after Busy drops
    task automatic runOp(input string tag, input logic [1:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic hw, input logic lw, input int n,
                         input logic [31:0] expHi, input logic [31:0] expLo);
        int busyCnt;
        int doneCnt;
        Start = 1'b1; MDOp = op; A = a; B = b; HIWrite = hw; LOWrite = lw;
        @(posedge clk);
        #1 Start = 1'b0; HIWrite = 1'b0; LOWrite = 1'b0; A = 32'hDEAD_BEEF; B = 32'h0BAD_F00D;
        busyCnt = 0;
        doneCnt = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (Done) doneCnt++;
            if (Busy) busyCnt++;
            else break;
        end
        checkVal({tag, ".busy"}, 64'(busyCnt), 64'(n));
        checkVal({tag, ".done"}, 64'(doneCnt), 64'd1);
        checkHiLo(tag, expHi, expLo);
    endtask

    task automatic moveTo(input logic hw, input logic lw, input logic [31:0] val);
        HIWrite = hw; LOWrite = lw; A = val;
        @(posedge clk);
        #1 HIWrite = 1'b0; LOWrite = 1'b0; A = 32'h5555_AAAA;
        @(negedge clk);
    endtask

    initial begin
        int doneCnt;
        reset = 1'b1; Start = 1'b0; MDOp = 2'b00; A = 32'd0; B = 32'd0;
        HIWrite = 1'b0; LOWrite = 1'b0; MFSel = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        checkVal("rst.busy", {63'd0, Busy}, 64'd0);
        checkVal("rst.done", {63'd0, Done}, 64'd0);
        checkHiLo("rst", 32'd0, 32'd0);

        runOp("mult", 2'b00, 32'd7, 32'hFFFF_FFFD, 1'b0, 1'b0, 5, 32'hFFFF_FFFF, 32'hFFFF_FFEB);
        runOp("multu", 2'b01, 32'hFFFF_FFFF, 32'd2, 1'b0, 1'b0, 5, 32'h0000_0001, 32'hFFFF_FFFE);
        runOp("div", 2'b10, 32'hFFFF_FFF9, 32'd2, 1'b0, 1'b0, 10, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        runOp("divovf", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0, 10, 32'd0, 32'h8000_0000);
        runOp("divu", 2'b11, 32'd100, 32'd7, 1'b0, 1'b0, 10, 32'd2, 32'd14);

        moveTo(1'b1, 1'b0, 32'h1111_1111);
        checkHiLo("mthi", 32'h1111_1111, 32'd14);
        moveTo(1'b0, 1'b1, 32'h2222_2222);
        checkHiLo("mtlo", 32'h1111_1111, 32'h2222_2222);
        runOp("divu0", 2'b11, 32'd7, 32'd0, 1'b0, 1'b0, 10, 32'h1111_1111, 32'h2222_2222);

        moveTo(1'b1, 1'b1, 32'h3333_3333);
        checkHiLo("mtboth", 32'h3333_3333, 32'h3333_3333);
        // Start wins over the writes: a zero-divisor op leaves the old HI/LO visible
        runOp("startwr0", 2'b10, 32'd9, 32'd0, 1'b1, 1'b1, 10, 32'h3333_3333, 32'h3333_3333);
        runOp("startmthi", 2'b00, 32'd7, 32'hFFFF_FFFD, 1'b1, 1'b0, 5, 32'hFFFF_FFFF, 32'hFFFF_FFEB);

        // back-to-back: second op issued in the Done cycle of the first
        runOp("b2b1", 2'b01, 32'h0001_0000, 32'h0001_0000, 1'b0, 1'b0, 5, 32'd1, 32'd0);
        runOp("b2b2", 2'b10, 32'd20, 32'hFFFF_FFFA, 1'b0, 1'b0, 10, 32'd2, 32'hFFFF_FFFD);

        // reset on the third busy cycle of a div
        Start = 1'b1; MDOp = 2'b10; A = 32'd50; B = 32'd3;
        @(posedge clk);
        #1 Start = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        checkVal("abort.busy", {63'd0, Busy}, 64'd0);
        checkVal("abort.done", {63'd0, Done}, 64'd0);
        checkHiLo("abort", 32'd0, 32'd0);
        doneCnt = 0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (Done) doneCnt++;
        end
        checkVal("abort.nodone", 64'(doneCnt), 64'd0);
        checkHiLo("abort.hold", 32'd0, 32'd0);

        runOp("post", 2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0, 5, 32'd0, 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/md_unit.md
# md_unit

Multiply/divide unit for the EX stage of the 5-stage pipeline. It owns the architectural HI/LO registers and executes mult, multu, div, divu, mthi and mtlo over multiple cycles. It exposes Busy to the hazard unit, which stalls any later md instruction or mfhi/mflo until Busy clears. MDOut (mfhi/mflo data) enters the EX/MEM ALUOut path, so it reaches ALUOutM like any ALU result.

## Interface
- MULT_CYCLES, 5, busy cycles for mult/multu (≥1)
- DIV_CYCLES, 10, busy cycles for div/divu (≥1)

- clk  input  1  clock, rising edge
- reset  input  1  synchronous, active-high
- Start  input  1  issue md op this cycle (EX stage, not flushed)
- MDOp  input  2  00 mult, 01 multu, 10 div, 11 divu
- A  input  32  rs operand (forwarded)
- B  input  32  rt operand (forwarded)
- HIWrite  input  1  mthi: HI <= A
- LOWrite  input  1  mtlo: LO <= A
- MFSel  input  1  0 selects LO, 1 selects HI
- MDOut  output  32  combinational: MFSel ? HI : LO
- Busy  output  1  operation in flight
- Done  output  1  one-cycle pulse when HI/LO take the result

## Operation
- Registers: HI, LO, Cnt (log2 of max cycles, sized to hold DIV_CYCLES), Busy, Done, latched result pair.
- States: IDLE (Busy=0), RUN (Busy=1).
- IDLE, Start=1 at an edge:
  - Compute the result from A, B, MDOp and latch it.
  - Cnt <= MULT_CYCLES or DIV_CYCLES.
  - Busy <= 1, go to RUN.
- RUN, at each edge:
  - Cnt <= Cnt-1.
  - When Cnt==1: write the latched result to HI/LO, Busy <= 0, Done <= 1, return to IDLE.
- Done is 0 in all other cycles.
- Arithmetic:
  - mult: signed 32x32 to 64, {HI,LO}.
  - multu: unsigned 32x32 to 64, {HI,LO}.
  - div: LO = quotient truncated toward zero, HI = remainder with the sign of the dividend.
  - div with 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0.
  - divu: unsigned quotient/remainder.
  - Divide by zero (B==0): full busy time elapses, Done pulses, HI and LO keep their prior values.
- mthi/mtlo:
  - Take effect at the edge only in IDLE with Start=0.
  - HIWrite and LOWrite may both be set; both registers then load A.
- Simultaneous events:
  - Start with HIWrite/LOWrite in IDLE: Start wins, the writes are ignored.
  - Start, HIWrite or LOWrite during RUN: ignored. The hazard unit must prevent this, and the bench flags it as a protocol error.
- Reset:
  - HI=0, LO=0, Cnt=0, Busy=0, Done=0, state IDLE, so MDOut=0.
  - Reset during RUN aborts the operation. HI/LO are zeroed and no Done is produced.

## Timing
- Start sampled at edge k:
  - Busy=1 in cycles k+1 through k+N (N = latency parameter).
  - HI/LO are updated at edge k+N, so Busy is high for exactly N cycles.
  - Done=1 and the new MDOut are visible in cycle k+N+1.
- Back-to-back issue: Start may be asserted in the cycle Done=1 (Busy=0). The new op's operands do not disturb the HI/LO just written.
- mthi/mtlo at edge k: MDOut reflects the new value in cycle k+1. There is no internal bypass from A to MDOut.
- MDOut is purely combinational from HI/LO/MFSel, with zero latency.
- Busy is registered and glitch-free, so it is safe for the stall path.

## Test plan
- Reset, then mult A=7, B=0xFFFFFFFD:
  - Busy high for exactly 5 cycles, Done pulses once.
  - HI=0xFFFFFFFF, LO=0xFFFFFFEB.
- multu A=0xFFFFFFFF, B=2 -> HI=0x00000001, LO=0xFFFFFFFE after 5 busy cycles.
- div A=0xFFFFFFF9 (-7), B=2 -> after 10 busy cycles LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- div 0x80000000 / 0xFFFFFFFF -> LO=0x80000000, HI=0.
- divu A=7, B=0, with HI/LO preloaded by mthi 0x11111111 / mtlo 0x22222222:
  - Done after 10 cycles.
  - HI/LO unchanged.
- Boundary cases:
  - Start with mthi in the same IDLE cycle: mult result wins.
  - Reset asserted on the 3rd busy cycle of div: Busy=0, HI=LO=0 next cycle, no Done.
  - Start issued in the Done cycle: next op completes correctly.
